ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: execute-stage result valid this cycle.
REQ-004 SHALL have ports ALU_result and st_value, input, 16 bits each: address or result, and store data, from execute.
REQ-005 SHALL have ports mem_read, mem_write, reg_write and halt, input, 1 bit each: decoded control carried from execute.
REQ-006 SHALL have port wr_reg, input, 3 bits: destination register.
REQ-007 SHALL have ports mem_req and mem_we, output, 1 bit each: data-memory request and write enable.
REQ-008 SHALL have ports mem_addr and mem_wdata, output, 16 bits each: data-memory address and write data.
REQ-009 SHALL have port mem_ack, input, 1 bit: memory completes the access this cycle.
REQ-010 SHALL have port mem_rdata, input, 16 bits: read data, valid with mem_ack.
REQ-011 SHALL have port stall, output, 1 bit: hold execute and all upstream stages.
REQ-012 SHALL have ports out_valid, wb_en and err, output, 1 bit each: writeback-stage valid, register write enable, and sticky error.
REQ-013 SHALL have port wb_data, output, 16 bits: writeback value.
REQ-014 SHALL have port wb_reg, output, 3 bits: writeback register.
REQ-015 SHALL have ports EX_MEM_Data (16 bits), EX_MEM_reg (3 bits) and EX_MEM_regwrite (1 bit), output: registered forwarding source for execute.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_ACK, DONE and ERROR.
REQ-017 In IDLE, an in_valid op with neither mem_read nor mem_write SHALL register ALU_result and control, then present them with out_valid=1 the next cycle (1-cycle latency, no stall).
REQ-018 In IDLE, an in_valid op with mem_read or mem_write SHALL latch the address, data and control, enter WAIT_ACK, and assert mem_req on the next cycle.
REQ-019 In WAIT_ACK, mem_req SHALL stay high, with mem_addr, mem_wdata and mem_we held constant, until mem_ack is sampled high.
REQ-020 stall SHALL be 1 in every cycle from WAIT_ACK entry until the cycle mem_ack is sampled, inclusive; upstream inputs SHALL be ignored while stall=1.
REQ-021 On mem_ack, the FSM SHALL enter DONE, and mem_req SHALL deassert the following cycle.
REQ-022 In DONE, the stage SHALL present out_valid=1 for exactly one cycle.
REQ-023 In DONE, wb_data SHALL be mem_rdata captured at ack for loads, and the latched ALU_result otherwise.
REQ-024 The FSM SHALL leave DONE for IDLE, or directly accept a new in_valid op in that same cycle.
REQ-025 A memory op whose address has bit 0 = 1 SHALL NOT issue mem_req, SHALL set err, and SHALL enter ERROR.
REQ-026 A 16-bit wait counter SHALL increment each WAIT_ACK cycle; reaching 0xFFFF without ack SHALL set err, drop mem_req and enter ERROR.
REQ-027 ERROR SHALL be terminal until reset: stall=1, out_valid=0, err=1.
REQ-028 halt SHALL propagate as a writeback-valid op with wb_en=0.
REQ-029 wb_en SHALL equal out_valid AND the latched reg_write.
REQ-030 EX_MEM_Data, EX_MEM_reg and EX_MEM_regwrite SHALL reflect the registered op (EX_MEM_regwrite=0 when no valid op is held, or while a load has not yet acked).
REQ-031 in_valid=0 in IDLE SHALL produce a bubble: out_valid=0, no memory request.

Reset
REQ-032 rst low SHALL immediately force IDLE, counter=0 and every output to 0, including mid-access: mem_req drops with no completion expected.
REQ-033 The first op SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-034 FSM state encodings and the timeout constant 0xFFFF SHALL live in the shared processor package.
REQ-035 The memory handshake FSM plus counter SHALL be one sub-module, mem_access_ctrl; the pipeline registers stay in ex_mem_stage.

Verification
REQ-036 Bench: ALU op (ALU_result=0x1234, reg_write=1, wr_reg=3) -> next cycle out_valid=1, wb_data=0x1234, wb_reg=3, wb_en=1, stall=0.
REQ-037 Bench: load addr 0x0040, mem_ack after 3 cycles with rdata 0xBEEF -> stall high 4 cycles, then wb_data=0xBEEF for one cycle.
REQ-038 Bench: store addr 0x0010, data 0x00AA, ack immediately -> mem_we=1 with stable addr/data, wb_en=0, one stall cycle.
REQ-039 Bench: load addr 0x0011 -> no mem_req, err=1, stall stuck at 1 until rst.
REQ-040 Bench: rst pulled low during WAIT_ACK -> all outputs 0 at once; after release, an ALU op completes normally.
REQ-041 Bench: no ack for 0xFFFF cycles -> err=1, mem_req=0, FSM in ERROR.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared processor package: memory-access FSM encoding and the access timeout limit.
package ex_mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2,
        ERROR    = 2'd3
    } mem_state_e;

    localparam logic [15:0] TIMEOUT_CNT = 16'hFFFF;

endpackage

// File: rtl/mem_access_ctrl.sv
// Data-memory handshake FSM: issues mem_req, waits for ack, times out or flags misalignment.
module mem_access_ctrl
    import ex_mem_stage_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic accept_i,
    input  logic is_mem_i,
    input  logic misalign_i,
    input  logic mem_ack_i,
    output logic mem_req_o,
    output logic stall_o,
    output logic err_o,
    output logic done_o
);

    mem_state_e  state_q;
    logic [15:0] cnt_q;
    logic        mem_req_q;
    logic        stall_q;
    logic        err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            mem_req_q <= 1'b0;
            stall_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    stall_q   <= 1'b0;
                    if (accept_i && is_mem_i) begin
                        stall_q <= 1'b1;
                        if (misalign_i) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q   <= WAIT_ACK;
                            mem_req_q <= 1'b1;
                            cnt_q     <= 16'd0;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (mem_ack_i) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        stall_q   <= 1'b0;
                    end else if (cnt_q + 16'd1 == TIMEOUT_CNT) begin
                        // Counter has reached the limit without an ack; abandon the access.
                        state_q   <= ERROR;
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        cnt_q     <= TIMEOUT_CNT;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q   <= ERROR;
                    mem_req_q <= 1'b0;
                    stall_q   <= 1'b1;
                    err_q     <= 1'b1;
                end
            endcase
        end
    end

    assign mem_req_o = mem_req_q;
    assign stall_o   = stall_q;
    assign err_o     = err_q;
    assign done_o    = (state_q == WAIT_ACK) && mem_ack_i;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: holds the execute result, runs data-memory accesses, feeds writeback.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] ALU_result,
    input  logic [15:0] st_value,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        halt,
    input  logic [2:0]  wr_reg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        out_valid,
    output logic        wb_en,
    output logic        err,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_reg,
    output logic [15:0] EX_MEM_Data,
    output logic [2:0]  EX_MEM_reg,
    output logic        EX_MEM_regwrite
);

    logic        accept;
    logic        mem_done;

    logic        op_valid_q, op_valid_d;
    logic        op_load_q,  op_load_d;
    logic        op_we_q,    op_we_d;
    logic        op_rw_q,    op_rw_d;
    logic [2:0]  op_reg_q,   op_reg_d;
    logic [15:0] addr_q,     addr_d;
    logic [15:0] wdata_q,    wdata_d;
    logic [15:0] data_q,     data_d;
    logic        out_valid_q, out_valid_d;

    assign accept = in_valid & ~stall;

    mem_access_ctrl u_ctrl (
        .clk_i      (clk),
        .rst_n_i    (rst),
        .accept_i   (accept),
        .is_mem_i   (mem_read | mem_write),
        .misalign_i (ALU_result[0]),
        .mem_ack_i  (mem_ack),
        .mem_req_o  (mem_req),
        .stall_o    (stall),
        .err_o      (err),
        .done_o     (mem_done)
    );

    always_comb begin
        op_valid_d  = op_valid_q;
        op_load_d   = op_load_q;
        op_we_d     = op_we_q;
        op_rw_d     = op_rw_q;
        op_reg_d    = op_reg_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        out_valid_d = 1'b0;
        if (accept) begin
            op_valid_d  = 1'b1;
            op_load_d   = mem_read;
            op_we_d     = mem_write;
            // A halt reaches writeback as a valid op that never writes the register file.
            op_rw_d     = reg_write & ~halt;
            op_reg_d    = wr_reg;
            addr_d      = ALU_result;
            wdata_d     = st_value;
            data_d      = ALU_result;
            out_valid_d = ~(mem_read | mem_write);
        end else if (mem_done) begin
            out_valid_d = 1'b1;
            if (op_load_q) begin
                data_d = mem_rdata;
            end
        end else if (!stall) begin
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_valid_q  <= 1'b0;
            op_load_q   <= 1'b0;
            op_we_q     <= 1'b0;
            op_rw_q     <= 1'b0;
            op_reg_q    <= 3'd0;
            addr_q      <= 16'd0;
            wdata_q     <= 16'd0;
            data_q      <= 16'd0;
            out_valid_q <= 1'b0;
        end else begin
            op_valid_q  <= op_valid_d;
            op_load_q   <= op_load_d;
            op_we_q     <= op_we_d;
            op_rw_q     <= op_rw_d;
            op_reg_q    <= op_reg_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_req & op_we_q;

    assign out_valid = out_valid_q;
    assign wb_en     = out_valid_q & op_rw_q;
    assign wb_data   = data_q;
    assign wb_reg    = op_reg_q;

    // Forwarding must not offer a load's address as if it were the loaded value.
    assign EX_MEM_Data     = data_q;
    assign EX_MEM_reg      = op_reg_q;
    assign EX_MEM_regwrite = op_valid_q & op_rw_q & ~err & ~(op_load_q & stall);

endmodule
